// File: rtl/fir_pkg.sv
// Constants shared by the FIR filter, its sample feeder and their benches.
package fir_pkg;

  localparam int FIR_DW   = 8;
  localparam int FIR_TAPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous FIFO holding samples between the upstream producer and the feeder.
// clear wins over push and pop in the same cycle.
module fir_sample_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered samples to filterfir at a programmable rate, with a strobe per sample,
// and emits TAPS zeros on flush so the filter's delay line drains cleanly.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DIV_W = 8,
  parameter int TAPS  = FIR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             flush_req,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    x,
  output logic             x_stb,
  output logic             underrun,
  output logic             busy,
  output logic [AW:0]      level
);

  localparam int ZW = $clog2(TAPS + 1);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [ZW-1:0]    zcnt;
  logic             period_end;
  logic             fire;
  logic             pop;
  logic             clear;
  logic             load_div;
  logic             clr_under;
  logic [DW-1:0]    head;
  logic             full;
  logic             empty;

  assign period_end = (state != ST_IDLE) && (cnt == div_q);
  assign in_ready   = !full && (state != ST_FLUSH);
  assign busy       = (state != ST_IDLE);

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .clear (clear),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // load_div restarts the period and samples a fresh div; it happens on every state
  // entry into RUN/FLUSH and at every strobe.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    load_div   = 1'b0;
    clr_under  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          next_state = ST_FLUSH;
          clear      = 1'b1;
          load_div   = 1'b1;
        end else if (enable) begin
          next_state = ST_RUN;
          load_div   = 1'b1;
          clr_under  = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          next_state = ST_FLUSH;
          clear      = 1'b1;
          load_div   = 1'b1;
        end else if (!enable) begin
          next_state = ST_IDLE;
        end else if (period_end) begin
          fire     = 1'b1;
          pop      = !empty;
          load_div = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (period_end) begin
          fire     = 1'b1;
          load_div = 1'b1;
          if (zcnt == ZW'(TAPS - 1)) next_state = enable ? ST_RUN : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= '0;
      zcnt  <= '0;
    end else begin
      if (load_div) begin
        cnt   <= '0;
        div_q <= div;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + DIV_W'(1);
      end
      if (clear)                            zcnt <= '0;
      else if (fire && state == ST_FLUSH)   zcnt <= zcnt + ZW'(1);
    end
  end

  // An empty FIFO at a RUN strobe sends a zero rather than stalling the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= '0;
      x_stb    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      x_stb <= fire;
      if (fire) x <= (state == ST_RUN && !empty) ? head : '0;
      if (clr_under)                                  underrun <= 1'b0;
      else if (fire && state == ST_RUN && empty)      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed and randomized checks of fir_sample_feeder against a queue-based model of the
// sample stream.
module tb_fir_sample_feeder;
  import fir_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             flush_req = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    x;
  logic             x_stb;
  logic             underrun;
  logic             busy;
  logic [AW:0]      level;

  int checks_passed = 0;
  int checks_failed = 0;
  int checks_total  = 0;

  always #5 clk = ~clk;

  fir_sample_feeder #(
    .DW (DW), .DEPTH (DEPTH), .AW (AW), .DIV_W (DIV_W), .TAPS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .div       (div),
    .flush_req (flush_req),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .x_stb     (x_stb),
    .underrun  (underrun),
    .busy      (busy),
    .level     (level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges up to and including the next strobe; the bound keeps a dead DUT from hanging us.
  task automatic wait_stb(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!x_stb && n < exp_n + 4);
    check(tag, n, exp_n);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] stream [5];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mq [$];
    logic [DW-1:0] mx;
    logic [DW-1:0] d;
    logic          exp_under;
    logic          push_ok;
    logic          exp_stb;
    int            since;
    int            rdiv;
    int            nstb;

    stream = '{8'd5, 8'd10, 8'd12, 8'd15, 8'd16};

    #12;
    check("reset_x", x, 0);
    check("reset_x_stb", x_stb, 0);
    check("reset_underrun", underrun, 0);
    check("reset_level", level, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // Stream five samples at div=1, then one underrun strobe.
    div = 8'd1;
    for (int i = 0; i < 5; i++) push_val(stream[i]);
    check("stream_level", level, 5);
    enable = 1'b1;
    tick();
    check("stream_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      wait_stb("stream_period", 2);
      check("stream_x", x, stream[i]);
      check("stream_no_underrun", underrun, 0);
    end
    wait_stb("stream_period_under", 2);
    check("stream_under_x", x, 0);
    check("stream_underrun", underrun, 1);
    tick();
    check("stream_stb_one_cycle", x_stb, 0);
    enable = 1'b0;
    tick();
    check("stream_idle", busy, 0);

    // Fill to full at div=0; the ninth push must be dropped.
    div = 8'd0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      push_val(d);
    end
    check("full_level", level, 8);
    check("full_in_ready", in_ready, 0);
    push_val(8'hAA);
    check("full_drop_level", level, 8);
    enable = 1'b1;
    tick();
    check("full_underrun_cleared", underrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      wait_stb("full_period", 1);
      check("full_x", x, exp_q.pop_front());
    end
    enable = 1'b0;
    tick();
    check("full_stop_no_stb", x_stb, 0);
    check("full_idle", busy, 0);
    check("full_drained", level, 0);

    // Flush from IDLE with enable low: four zeros, then back to IDLE.
    div = 8'd1;
    push_val(8'h11);
    push_val(8'h22);
    push_val(8'h33);
    check("flush_pre_level", level, 3);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_level_cleared", level, 0);
    check("flush_in_ready", in_ready, 0);
    check("flush_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      wait_stb("flush_period", 2);
      check("flush_zero", x, 0);
    end
    check("flush_to_idle", busy, 0);
    nstb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (x_stb) nstb++;
    end
    check("flush_no_extra_stb", nstb, 0);

    // flush_req beats enable in IDLE; with enable held the stream resumes afterwards.
    push_val(8'h44);
    push_val(8'h55);
    enable    = 1'b1;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush2_level_cleared", level, 0);
    for (int i = 0; i < 4; i++) begin
      wait_stb("flush2_period", 2);
      check("flush2_zero", x, 0);
    end
    check("flush2_resume_busy", busy, 1);
    push_val(8'h66);
    wait_stb("flush2_resume_period", 1);
    check("flush2_resume_x", x, 8'h66);
    enable = 1'b0;
    tick();

    // A push landing on an empty-FIFO strobe is not bypassed.
    div    = 8'd2;
    enable = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    in_valid = 1'b0;
    check("race_stb", x_stb, 1);
    check("race_x", x, 0);
    check("race_underrun", underrun, 1);
    check("race_level", level, 1);
    wait_stb("race_period", 3);
    check("race_next_x", x, 8'd7);
    enable = 1'b0;
    tick();

    // Dropping enable on the edge a strobe was due suppresses it and keeps the queue.
    div = 8'd3;
    push_val(8'h41);
    enable = 1'b1;
    tick();
    wait_stb("stop_period", 4);
    check("stop_first_x", x, 8'h41);
    push_val(8'h42);
    push_val(8'h43);
    tick();
    enable = 1'b0;
    tick();
    check("stop_no_stb", x_stb, 0);
    check("stop_x_hold", x, 8'h41);
    check("stop_busy", busy, 0);
    check("stop_level", level, 2);
    nstb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (x_stb) nstb++;
    end
    check("stop_quiet", nstb, 0);
    check("stop_level_kept", level, 2);

    // Asynchronous reset between edges while running with three samples queued.
    push_val(8'h0A);
    div    = 8'd7;
    enable = 1'b1;
    tick();
    tick();
    check("arst_pre_level", level, 3);
    check("arst_pre_busy", busy, 1);
    #3 rst = 1'b0;
    #1;
    check("arst_x", x, 0);
    check("arst_x_stb", x_stb, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Randomized producer against a queue model of the stream.
    mq.delete();
    mx = '0;
    for (int r = 0; r < 3; r++) begin
      rdiv   = (r == 0) ? 3 : (r == 1) ? 0 : int'($urandom_range(1, 2));
      div    = DIV_W'(rdiv);
      enable = 1'b1;
      tick();
      since     = 0;
      exp_under = 1'b0;
      check("rnd_entry_underrun", underrun, 0);
      for (int c = 0; c < 40; c++) begin
        d        = 8'($urandom);
        in_data  = d;
        in_valid = ($urandom_range(0, 2) != 0);
        check("rnd_in_ready", in_ready, mq.size() < DEPTH);
        push_ok = in_valid && (mq.size() < DEPTH);
        tick();
        since++;
        exp_stb = (since == rdiv + 1);
        if (exp_stb) begin
          since = 0;
          if (mq.size() > 0) mx = mq.pop_front();
          else begin
            mx        = '0;
            exp_under = 1'b1;
          end
        end
        if (push_ok) mq.push_back(d);
        check("rnd_x_stb", x_stb, exp_stb);
        check("rnd_x", x, mx);
        check("rnd_level", level, mq.size());
        check("rnd_underrun", underrun, exp_under);
      end
      in_valid = 1'b0;
      enable   = 1'b0;
      tick();
      check("rnd_stop_no_stb", x_stb, 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
